// File: rtl/instruction_fetch.sv
// Instruction-fetch unit: owns the PC, drives a synchronous-read ROM and tags
// each returned word with its PC. Stalls re-read the ROM; bad addresses trap.
//
// state | meaning
// IDLE  | waiting for start, pc parked at its reset/restart value
// RUN   | issuing one address per cycle, delivering the previous one
// FAULT | illegal fetch address seen; sticky until reset
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS) << 2;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] rsp_pc, rsp_pc_nxt;
  logic        rsp_valid, rsp_valid_nxt;
  logic [31:0] fault_pc_nxt;

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < IMEM_BYTES);
  endfunction

  assign if_instr    = rsp_valid ? imem_instr : 32'h0;
  assign if_pc       = rsp_pc;
  assign if_pc_plus4 = rsp_pc + 32'd4;
  assign if_valid    = rsp_valid && (state == RUN) && !redirect;
  assign fault       = (state == FAULT);

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    rsp_pc_nxt    = rsp_pc;
    rsp_valid_nxt = rsp_valid;
    fault_pc_nxt  = fault_pc;
    imem_addr     = rsp_pc;
    case (state)
      IDLE: begin
        imem_addr = pc;
        if (start) begin
          if (legal(pc)) begin
            rsp_pc_nxt    = pc;
            pc_nxt        = pc + 32'd4;
            rsp_valid_nxt = 1'b1;
            state_nxt     = RUN;
          end else begin
            fault_pc_nxt = pc;
            state_nxt    = FAULT;
          end
        end
      end
      RUN: begin
        if (redirect) begin
          imem_addr = redirect_pc;
          if (legal(redirect_pc)) begin
            rsp_pc_nxt    = redirect_pc;
            pc_nxt        = redirect_pc + 32'd4;
            rsp_valid_nxt = 1'b1;
          end else begin
            fault_pc_nxt  = redirect_pc;
            rsp_valid_nxt = 1'b0;
            state_nxt     = FAULT;
          end
        end else if (stall) begin
          // re-read the word already on imem_instr so no holding buffer is needed
          imem_addr = rsp_pc;
        end else begin
          imem_addr = pc;
          if (legal(pc)) begin
            rsp_pc_nxt = pc;
            pc_nxt     = pc + 32'd4;
          end else begin
            fault_pc_nxt  = pc;
            rsp_valid_nxt = 1'b0;
            state_nxt     = FAULT;
          end
        end
      end
      FAULT: imem_addr = rsp_pc;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rsp_valid   <= 1'b0;
      fault_pc    <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      rsp_pc    <= rsp_pc_nxt;
      rsp_valid <= rsp_valid_nxt;
      fault_pc  <= fault_pc_nxt;
      if (if_valid && !stall)
        fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 1024-word synchronous ROM model
// holding word i = 32'h1000_0000 + i.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int passed = 0;

  logic [31:0] mem [0:1023];

  instruction_fetch dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .if_valid(if_valid), .fault(fault), .fault_pc(fault_pc),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_instr <= mem[imem_addr[11:2]];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    start = 0; stall = 0; redirect = 0; redirect_pc = 32'h0;
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset;
    start = 0; stall = 0; redirect = 0; redirect_pc = 32'h0;
    #2;
    reset = 1;
    #1;
    checks++; if (if_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", if_valid); else passed++;
    checks++; if (if_instr !== 32'h0) $display("FAIL rst_instr got %h want 0", if_instr); else passed++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", imem_addr); else passed++;
    checks++; if (if_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", if_pc); else passed++;
    checks++; if (if_pc_plus4 !== 32'h4) $display("FAIL rst_pc4 got %h want 4", if_pc_plus4); else passed++;
    checks++; if (fault !== 1'b0) $display("FAIL rst_fault got %b want 0", fault); else passed++;
    checks++; if (fault_pc !== 32'h0) $display("FAIL rst_fault_pc got %h want 0", fault_pc); else passed++;
    checks++; if (fetch_count !== 32'h0) $display("FAIL rst_count got %h want 0", fetch_count); else passed++;
    tick();
    tick();
    checks++; if (if_valid !== 1'b0) $display("FAIL idle_valid got %b want 0", if_valid); else passed++;
    reset = 0;
  endtask

  task automatic test_sequential;
    do_reset();
    start = 1;
    #1;
    checks++; if (imem_addr !== 32'h0) $display("FAIL seq_start_addr got %h want 0", imem_addr); else passed++;
    checks++; if (if_valid !== 1'b0) $display("FAIL seq_start_valid got %b want 0", if_valid); else passed++;
    tick();
    start = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (if_valid !== 1'b1) $display("FAIL seq_valid[%0d] got %b want 1", k, if_valid); else passed++;
      checks++; if (if_pc !== 32'(4 * k)) $display("FAIL seq_pc[%0d] got %h want %h", k, if_pc, 32'(4 * k)); else passed++;
      checks++; if (if_instr !== 32'h1000_0000 + 32'(k)) $display("FAIL seq_instr[%0d] got %h want %h", k, if_instr, 32'h1000_0000 + 32'(k)); else passed++;
      checks++; if (if_pc_plus4 !== 32'(4 * k + 4)) $display("FAIL seq_pc4[%0d] got %h want %h", k, if_pc_plus4, 32'(4 * k + 4)); else passed++;
      checks++; if (imem_addr !== 32'(4 * k + 4)) $display("FAIL seq_addr[%0d] got %h want %h", k, imem_addr, 32'(4 * k + 4)); else passed++;
      tick();
    end
    #1;
    checks++; if (fetch_count !== 32'd8) $display("FAIL seq_count got %0d want 8", fetch_count); else passed++;
  endtask

  task automatic test_stall;
    do_reset();
    start = 1;
    #1;
    tick();
    start = 0;
    tick();
    tick();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (if_pc !== 32'h8) $display("FAIL stall_pc[%0d] got %h want 8", k, if_pc); else passed++;
      checks++; if (if_instr !== 32'h1000_0002) $display("FAIL stall_instr[%0d] got %h want 10000002", k, if_instr); else passed++;
      checks++; if (imem_addr !== 32'h8) $display("FAIL stall_addr[%0d] got %h want 8", k, imem_addr); else passed++;
      checks++; if (fetch_count !== 32'd2) $display("FAIL stall_count[%0d] got %0d want 2", k, fetch_count); else passed++;
      tick();
    end
    stall = 0;
    #1;
    checks++; if (if_pc !== 32'h8 || if_valid !== 1'b1) $display("FAIL stall_release got pc %h valid %b want pc 8 valid 1", if_pc, if_valid); else passed++;
    checks++; if (if_instr !== 32'h1000_0002) $display("FAIL stall_release_instr got %h want 10000002", if_instr); else passed++;
    tick();
    #1;
    checks++; if (if_pc !== 32'hC) $display("FAIL stall_next_pc got %h want c", if_pc); else passed++;
    checks++; if (if_instr !== 32'h1000_0003) $display("FAIL stall_next_instr got %h want 10000003", if_instr); else passed++;
    checks++; if (fetch_count !== 32'd3) $display("FAIL stall_once_count got %0d want 3", fetch_count); else passed++;
  endtask

  // continues from test_stall with if_pc = 12 on display
  task automatic test_redirect;
    redirect = 1;
    redirect_pc = 32'h40;
    #1;
    checks++; if (if_valid !== 1'b0) $display("FAIL redir_squash got %b want 0", if_valid); else passed++;
    checks++; if (imem_addr !== 32'h40) $display("FAIL redir_addr got %h want 40", imem_addr); else passed++;
    tick();
    redirect = 0;
    #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40) $display("FAIL redir_target got pc %h valid %b want pc 40 valid 1", if_pc, if_valid); else passed++;
    checks++; if (if_instr !== 32'h1000_0010) $display("FAIL redir_instr got %h want 10000010", if_instr); else passed++;
    checks++; if (fetch_count !== 32'd3) $display("FAIL redir_count got %0d want 3", fetch_count); else passed++;
    tick();
    #1;
    checks++; if (if_pc !== 32'h44 || if_instr !== 32'h1000_0011) $display("FAIL redir_follow got pc %h instr %h want pc 44 instr 10000011", if_pc, if_instr); else passed++;
    checks++; if (fetch_count !== 32'd4) $display("FAIL redir_follow_count got %0d want 4", fetch_count); else passed++;
  endtask

  // continues from test_redirect with if_pc = 0x44 on display
  task automatic test_redirect_stall;
    stall = 1;
    redirect = 1;
    redirect_pc = 32'h80;
    #1;
    checks++; if (if_valid !== 1'b0) $display("FAIL rs_squash got %b want 0", if_valid); else passed++;
    checks++; if (imem_addr !== 32'h80) $display("FAIL rs_addr got %h want 80", imem_addr); else passed++;
    tick();
    stall = 0;
    redirect = 0;
    #1;
    checks++; if (if_pc !== 32'h80 || if_instr !== 32'h1000_0020) $display("FAIL rs_target got pc %h instr %h want pc 80 instr 10000020", if_pc, if_instr); else passed++;
    checks++; if (fetch_count !== 32'd4) $display("FAIL rs_count got %0d want 4", fetch_count); else passed++;
    redirect = 1;
    redirect_pc = 32'h42;
    #1;
    checks++; if (if_valid !== 1'b0 || fault !== 1'b0) $display("FAIL bad_redir_pre got valid %b fault %b want 0 0", if_valid, fault); else passed++;
    tick();
    redirect = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (fault !== 1'b1) $display("FAIL bad_redir_fault[%0d] got %b want 1", k, fault); else passed++;
      checks++; if (fault_pc !== 32'h42) $display("FAIL bad_redir_fault_pc[%0d] got %h want 42", k, fault_pc); else passed++;
      checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0) $display("FAIL bad_redir_out[%0d] got valid %b instr %h want 0 0", k, if_valid, if_instr); else passed++;
      checks++; if (imem_addr !== 32'h80) $display("FAIL bad_redir_addr[%0d] got %h want 80", k, imem_addr); else passed++;
      tick();
    end
    checks++; if (fetch_count !== 32'd4) $display("FAIL bad_redir_count got %0d want 4", fetch_count); else passed++;
  endtask

  task automatic test_run_off;
    do_reset();
    start = 1;
    #1;
    tick();
    start = 0;
    redirect = 1;
    redirect_pc = 32'hFFC;
    #1;
    tick();
    redirect = 0;
    #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFC) $display("FAIL end_pc got pc %h valid %b want pc ffc valid 1", if_pc, if_valid); else passed++;
    checks++; if (if_instr !== 32'h1000_03FF) $display("FAIL end_instr got %h want 100003ff", if_instr); else passed++;
    checks++; if (if_pc_plus4 !== 32'h1000) $display("FAIL end_pc4 got %h want 1000", if_pc_plus4); else passed++;
    checks++; if (fault !== 1'b0) $display("FAIL end_early_fault got %b want 0", fault); else passed++;
    tick();
    #1;
    checks++; if (fault !== 1'b1 || fault_pc !== 32'h1000) $display("FAIL end_fault got fault %b pc %h want 1 1000", fault, fault_pc); else passed++;
    checks++; if (if_valid !== 1'b0) $display("FAIL end_valid got %b want 0", if_valid); else passed++;
    checks++; if (fetch_count !== 32'd1) $display("FAIL end_count got %0d want 1", fetch_count); else passed++;
    start = 1;
    redirect = 1;
    redirect_pc = 32'h0;
    tick();
    tick();
    start = 0;
    redirect = 0;
    #1;
    checks++; if (fault !== 1'b1 || if_valid !== 1'b0) $display("FAIL end_sticky got fault %b valid %b want 1 0", fault, if_valid); else passed++;
  endtask

  task automatic test_reset_midstream;
    do_reset();
    start = 1;
    #1;
    tick();
    start = 0;
    tick();
    tick();
    #2;
    reset = 1;
    #1;
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0) $display("FAIL mid_rst_out got valid %b instr %h want 0 0", if_valid, if_instr); else passed++;
    checks++; if (imem_addr !== 32'h0 || if_pc !== 32'h0) $display("FAIL mid_rst_addr got addr %h pc %h want 0 0", imem_addr, if_pc); else passed++;
    checks++; if (fetch_count !== 32'h0) $display("FAIL mid_rst_count got %0d want 0", fetch_count); else passed++;
    tick();
    reset = 0;
    #1;
    checks++; if (if_valid !== 1'b0) $display("FAIL mid_idle_valid got %b want 0", if_valid); else passed++;
    start = 1;
    #1;
    tick();
    start = 0;
    #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h1000_0000) $display("FAIL mid_restart got valid %b pc %h instr %h want 1 0 10000000", if_valid, if_pc, if_instr); else passed++;
    tick();
    #1;
    checks++; if (if_pc !== 32'h4 || if_instr !== 32'h1000_0001) $display("FAIL mid_restart2 got pc %h instr %h want 4 10000001", if_pc, if_instr); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
    reset = 0; start = 0; stall = 0; redirect = 0; redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_run_off();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch unit that drives the synchronous-read instruction memory and delivers fetched words to the IF/ID boundary of the MIPS pipeline. It owns the PC, issues one word address per cycle, and tracks the one-cycle memory read latency so each delivered instruction is tagged with its PC. It absorbs pipeline stalls and branch/jump redirects without a holding buffer, by re-reading the ROM. It traps illegal fetch addresses into a sticky fault state.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- IMEM_WORDS, 1024, instruction memory depth in words; legal byte addresses are 0 to IMEM_WORDS*4-1.

- clk  in  1  rising-edge clock.
- reset  in  1  reset: one clock; asynchronous, active-high.
- start  in  1  leave IDLE and begin fetching; ignored outside IDLE.
- stall  in  1  hold the current fetch output.
- redirect  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  32  redirect target byte address.
- imem_addr  out  32  byte address to instruction memory; data returns on imem_instr after the next rising edge.
- imem_instr  in  32  registered memory read data.
- if_instr  out  32  fetched instruction; 32'h0 (NOP) when if_valid=0.
- if_pc  out  32  PC of if_instr.
- if_pc_plus4  out  32  if_pc+4, modulo 2^32.
- if_valid  out  1  if_instr/if_pc are a live instruction.
- fault  out  1  sticky illegal-fetch flag.
- fault_pc  out  32  offending address.
- fetch_count  out  32  instructions delivered; wraps modulo 2^32.

## Operation
- Registers: pc (next address to issue), rsp_pc (address whose data is on imem_instr), rsp_valid, state (IDLE, RUN, FAULT), fault_pc, fetch_count.
- Illegal address: addr[1:0]!=0, or addr >= IMEM_WORDS*4.
- if_instr = rsp_valid ? imem_instr : 0. if_pc = rsp_pc. if_valid = rsp_valid & (state==RUN) & ~redirect.
- IDLE: imem_addr=pc. if_valid=0. stall and redirect are ignored.
  - start=1 with legal pc: rsp_pc<=pc, pc<=pc+4, rsp_valid<=1, go to RUN.
  - start=1 with illegal pc: fault_pc<=pc, go to FAULT.
- RUN: priority is redirect > stall > normal.
  - redirect, legal target: imem_addr=redirect_pc; rsp_pc<=redirect_pc; pc<=redirect_pc+4; rsp_valid<=1. The current output is squashed (if_valid=0).
  - redirect, illegal target: fault_pc<=redirect_pc; rsp_valid<=0; go to FAULT.
  - stall: imem_addr=rsp_pc, so the ROM re-reads the same word. All registers hold.
  - normal, legal pc: imem_addr=pc; rsp_pc<=pc; pc<=pc+4. The current output is delivered.
  - normal, illegal pc: the current output is still delivered this cycle. Then fault_pc<=pc, rsp_valid<=0, go to FAULT.
- FAULT: imem_addr=rsp_pc. if_valid=0. fault=1. Exits only on reset.
- fetch_count increments on each edge where if_valid=1 and stall=0.

## Timing
- Reset values (async, immediate): pc=RESET_PC, rsp_pc=RESET_PC, rsp_valid=0, state=IDLE, fault=0, fault_pc=0, fetch_count=0. Derived outputs: if_valid=0, if_instr=0, imem_addr=RESET_PC.
- Issue-to-deliver latency is 1 cycle. Throughput is 1 instruction per cycle with no stalls.
- Redirect costs exactly one squashed slot. The target instruction is valid in the cycle after redirect.
- Stall can be held for any number of cycles. if_instr/if_pc stay stable and the instruction is delivered once, on the first cycle with stall=0.
- A redirect that coincides with stall wins. The stalled instruction is discarded and not counted.
- imem_addr is combinational from state, registers, stall, redirect and redirect_pc.
- Reset asserted mid-RUN drops the in-flight word. After release, the unit restarts from IDLE.

## Test plan
- Sequential fetch: memory word i = 32'h1000_0000+i, start pulsed. Required: if_valid rises 1 cycle after start; if_pc = 0,4,8,...; if_instr = 0x10000000, 0x10000001, ...; fetch_count=8 after 8 valid cycles.
- Stall: assert stall for 3 cycles while if_pc=8. Required: if_pc=8 and if_instr=0x10000002 held for all 3 cycles; the next cycle delivers if_pc=12; word 2 is counted once.
- Redirect: redirect=1, redirect_pc=0x40 while if_pc=12. Required: if_valid=0 that cycle; next cycle if_pc=0x40 with if_instr=0x10000010; then 0x44 follows.
- Redirect+stall same cycle, and an illegal redirect (redirect_pc=0x42). Required: the redirect wins; for 0x42, fault=1, fault_pc=0x42, if_valid=0 permanently.
- Run-off end: redirect to 0xFFC. Required: 0xFFC is delivered; next cycle fault=1, fault_pc=0x1000; fault is sticky.
- Reset mid-stream: pulse reset asynchronously between edges. Required: outputs take reset values immediately; start then resumes fetching at RESET_PC.
